// File: rtl/dispatch_queue_pkg.sv
// rtl/dispatch_queue_pkg.sv - shared types and depth constant for the dispatch queue
package dispatch_queue_pkg;

  localparam int DISPATCH_DEPTH = 8;

  typedef enum logic [1:0] {
    UNIT_ALU,
    UNIT_MUL,
    UNIT_LDST,
    UNIT_BRANCH
  } unit_t;

  typedef enum logic [1:0] {
    LDST_NONE,
    LDST_LOAD,
    LDST_STORE
  } ldst_mode_t;

  typedef struct packed {
    logic       is_valid;
    logic [31:0] pc;
    unit_t      unit;
    ldst_mode_t ldst_mode;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
  } decode_result_t;

endpackage

// File: rtl/dispatch_queue_if.sv
// rtl/dispatch_queue_if.sv - decode-side and issue-side signal bundle for the dispatch queue
interface dispatch_queue_if
  import dispatch_queue_pkg::*;
#(
  parameter int DEPTH = DISPATCH_DEPTH
);

  logic                       flush;
  decode_result_t             in_entry  [2];
  logic                       in_ready;
  decode_result_t             out_entry [2];
  logic                       out_valid [2];
  logic                       deq_ready [2];
  logic [$clog2(DEPTH+1)-1:0] count;

  // Producer of decode pairs / consumer of issue slots (decode + issue side)
  modport master (
    output flush, in_entry, deq_ready,
    input  in_ready, out_entry, out_valid, count
  );

  // The queue itself
  modport slave (
    input  flush, in_entry, deq_ready,
    output in_ready, out_entry, out_valid, count
  );

endinterface

// File: rtl/dispatch_queue.sv
// rtl/dispatch_queue.sv - two-wide in-order FIFO between decode and issue
module dispatch_queue
  import dispatch_queue_pkg::*;
#(
  parameter int DEPTH = DISPATCH_DEPTH
) (
  input  logic            clk,
  input  logic            rst,
  dispatch_queue_if.slave dq
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  decode_result_t mem [DEPTH];
  logic [PW-1:0]  head;
  logic [PW-1:0]  tail;
  logic [CW-1:0]  count_q;

  logic           in_ready;
  logic [1:0]     n_enq;
  logic [1:0]     n_deq;
  logic           ov0;
  logic           ov1;
  decode_result_t first_wr;
  decode_result_t rd0;
  decode_result_t rd1;

  // Ready, push compaction, pop count and output view, all from registered state
  always_comb begin
    in_ready = (CW'(DEPTH) - count_q) >= CW'(2);
    n_enq    = {1'b0, dq.in_entry[0].is_valid} + {1'b0, dq.in_entry[1].is_valid};
    // When slot 0 is empty, slot 1 slides down to the tail position
    first_wr = dq.in_entry[0].is_valid ? dq.in_entry[0] : dq.in_entry[1];

    ov0 = count_q >= CW'(1);
    ov1 = count_q >= CW'(2);

    // Slot 1 alone never pops, keeping issue in program order
    n_deq = 2'd0;
    if (dq.deq_ready[0] && dq.deq_ready[1] && ov1) begin
      n_deq = 2'd2;
    end else if (dq.deq_ready[0] && ov0) begin
      n_deq = 2'd1;
    end

    rd0          = mem[head];
    rd1          = mem[head + PW'(1)];
    rd0.is_valid = ov0;
    rd1.is_valid = ov1;

    dq.in_ready     = in_ready;
    dq.out_valid[0] = ov0;
    dq.out_valid[1] = ov1;
    dq.out_entry[0] = rd0;
    dq.out_entry[1] = rd1;
    dq.count        = count_q;
  end

  // Storage, pointers and occupancy; flush and reset discard everything without touching the array
  always_ff @(posedge clk) begin
    if (rst || dq.flush) begin
      head    <= '0;
      tail    <= '0;
      count_q <= '0;
    end else begin
      if (in_ready && (n_enq != 2'd0)) begin
        mem[tail] <= first_wr;
        if (n_enq == 2'd2) begin
          mem[tail + PW'(1)] <= dq.in_entry[1];
        end
      end
      if (in_ready) begin
        tail <= tail + PW'(n_enq);
      end
      head    <= head + PW'(n_deq);
      count_q <= count_q + (in_ready ? CW'(n_enq) : CW'(0)) - CW'(n_deq);
    end
  end

endmodule

// File: tb/tb_dispatch_queue.sv
// tb/tb_dispatch_queue.sv - scoreboard bench for dispatch_queue
module tb_dispatch_queue;
  import dispatch_queue_pkg::*;

  localparam int D = 8;

  logic clk = 1'b0;
  logic rst;

  int errors = 0;
  int checks = 0;

  dispatch_queue_if #(.DEPTH(D)) dq ();

  dispatch_queue #(.DEPTH(D)) dut (
    .clk (clk),
    .rst (rst),
    .dq  (dq)
  );

  always #5 clk = ~clk;

  // Expected program-order contents of the queue (pc values)
  logic [31:0] exp_q [$];

  function automatic decode_result_t mk(input logic v, input logic [31:0] pc);
    decode_result_t e;
    e           = '0;
    e.is_valid  = v;
    e.pc        = pc;
    e.unit      = UNIT_ALU;
    e.ldst_mode = LDST_NONE;
    e.rd        = pc[6:2];
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Drive one cycle of stimulus, then wait until just after the edge that consumes it
  task automatic step(input logic v0, input logic [31:0] pc0,
                      input logic v1, input logic [31:0] pc1,
                      input logic dr0, input logic dr1, input logic fl);
    dq.in_entry[0]  = mk(v0, pc0);
    dq.in_entry[1]  = mk(v1, pc1);
    dq.deq_ready[0] = dr0;
    dq.deq_ready[1] = dr1;
    dq.flush        = fl;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
  endtask

  // Monitor: mid-cycle, compare outputs to the scoreboard, then apply this cycle's push/pop
  always @(negedge clk) begin
    int sz;
    int nd;
    sz = exp_q.size();
    if (rst) begin
      exp_q.delete();
    end else begin
      chk("mon_count", 32'(dq.count), 32'(sz));
      chk("mon_in_ready", 32'(dq.in_ready), 32'((D - sz) >= 2));
      chk("mon_out_valid0", 32'(dq.out_valid[0]), 32'(sz >= 1));
      chk("mon_out_valid1", 32'(dq.out_valid[1]), 32'(sz >= 2));
      chk("mon_is_valid0", 32'(dq.out_entry[0].is_valid), 32'(sz >= 1));
      chk("mon_is_valid1", 32'(dq.out_entry[1].is_valid), 32'(sz >= 2));
      if (sz >= 1) chk("mon_pc0", dq.out_entry[0].pc, exp_q[0]);
      if (sz >= 2) chk("mon_pc1", dq.out_entry[1].pc, exp_q[1]);

      if (dq.flush) begin
        exp_q.delete();
      end else begin
        nd = 0;
        if (dq.deq_ready[0] && dq.deq_ready[1] && sz >= 2) nd = 2;
        else if (dq.deq_ready[0] && sz >= 1) nd = 1;
        if ((D - sz) >= 2) begin
          if (dq.in_entry[0].is_valid) exp_q.push_back(dq.in_entry[0].pc);
          if (dq.in_entry[1].is_valid) exp_q.push_back(dq.in_entry[1].pc);
        end
        for (int k = 0; k < nd; k++) void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    logic [31:0] pc;
    rst             = 1'b1;
    dq.flush        = 1'b0;
    dq.in_entry[0]  = mk(1'b0, 32'h0);
    dq.in_entry[1]  = mk(1'b0, 32'h0);
    dq.deq_ready[0] = 1'b0;
    dq.deq_ready[1] = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state held over idle cycles
    for (int i = 0; i < 3; i++) begin
      chk("rst_count", 32'(dq.count), 32'd0);
      chk("rst_out_valid0", 32'(dq.out_valid[0]), 32'd0);
      chk("rst_out_valid1", 32'(dq.out_valid[1]), 32'd0);
      chk("rst_in_ready", 32'(dq.in_ready), 32'd1);
      idle();
    end

    // Compaction: only slot 1 valid, then a full pair with no dequeue
    step(1'b0, 32'h0, 1'b1, 32'h100, 1'b0, 1'b0, 1'b0);
    chk("cmp_count1", 32'(dq.count), 32'd1);
    step(1'b1, 32'h104, 1'b1, 32'h108, 1'b0, 1'b0, 1'b0);
    chk("cmp_pc0", dq.out_entry[0].pc, 32'h100);
    chk("cmp_pc1", dq.out_entry[1].pc, 32'h104);
    chk("cmp_count3", 32'(dq.count), 32'd3);
    step(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
    chk("pop2_pc0", dq.out_entry[0].pc, 32'h108);
    chk("pop2_valid1", 32'(dq.out_valid[1]), 32'd0);
    chk("pop2_count", 32'(dq.count), 32'd1);
    step(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    chk("drain_count", 32'(dq.count), 32'd0);

    // Fill to DEPTH with no dequeue
    pc = 32'h10c;
    for (int i = 0; i < 4; i++) begin
      step(1'b1, pc, 1'b1, pc + 32'd4, 1'b0, 1'b0, 1'b0);
      pc = pc + 32'd8;
    end
    chk("full_count", 32'(dq.count), 32'd8);
    chk("full_in_ready", 32'(dq.in_ready), 32'd0);
    step(1'b1, 32'h200, 1'b1, 32'h204, 1'b0, 1'b0, 1'b0);
    chk("ignored_count", 32'(dq.count), 32'd8);
    step(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    chk("pop1_count7", 32'(dq.count), 32'd7);
    chk("pop1_in_ready7", 32'(dq.in_ready), 32'd0);
    chk("pop1_pc0", dq.out_entry[0].pc, 32'h110);
    step(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    chk("pop1_count6", 32'(dq.count), 32'd6);
    chk("pop1_in_ready6", 32'(dq.in_ready), 32'd1);
    chk("pop1_pc0b", dq.out_entry[0].pc, 32'h114);

    // Steady state 2-in/2-out across pointer wrap, count held at 6
    for (int i = 0; i < 20; i++) begin
      step(1'b1, pc, 1'b1, pc + 32'd4, 1'b1, 1'b1, 1'b0);
      pc = pc + 32'd8;
      chk("steady_count", 32'(dq.count), 32'd6);
    end
    chk("steady_pc0", dq.out_entry[0].pc, pc - 32'd24);

    // Out-of-order accept is ignored
    step(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    chk("ooo_count", 32'(dq.count), 32'd6);
    step(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
    step(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
    step(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    chk("ooo_count1", 32'(dq.count), 32'd1);
    step(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
    chk("pop_one_of_one", 32'(dq.count), 32'd0);

    // Flush together with an enqueue and a pop
    step(1'b1, 32'h400, 1'b1, 32'h404, 1'b0, 1'b0, 1'b0);
    chk("pre_flush_count", 32'(dq.count), 32'd2);
    step(1'b1, 32'h300, 1'b1, 32'h304, 1'b1, 1'b1, 1'b1);
    chk("flush_count", 32'(dq.count), 32'd0);
    chk("flush_valid0", 32'(dq.out_valid[0]), 32'd0);
    chk("flush_is_valid0", 32'(dq.out_entry[0].is_valid), 32'd0);
    chk("flush_in_ready", 32'(dq.in_ready), 32'd1);
    idle();
    chk("post_flush_count", 32'(dq.count), 32'd0);

    // Enqueue resumes after flush; single slot 0 valid
    step(1'b1, 32'h500, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    chk("resume_pc0", dq.out_entry[0].pc, 32'h500);
    chk("resume_count", 32'(dq.count), 32'd1);
    step(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
